data_cache_ctrl: RTL and testbench
==================================

Name: data_cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage. It produces the hit and readData values that the MEM/WB register latches, and raises stall to freeze the pipeline during a miss refill or a write-through. On the memory side it drives a single-word req/ack handshake toward main memory.

Parameters:
LINES, 16, number of cache lines; power of two, at least 2.
WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
CLK  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
MemRead  in  1  load request from the MEM stage
MemWrite  in  1  store request from the MEM stage
address  in  32  byte address; bits [1:0] are ignored
writeData  in  32  store data
readData  out  32  load data; 0 whenever hit=0
hit  out  1  access satisfied this cycle
stall  out  1  freeze the pipeline
memReq  out  1  memory request, held until memAck
memWe  out  1  1 = memory write, 0 = memory read
memAddr  out  32  word-aligned memory address
memWriteData  out  32  memory write data
memReadData  in  32  memory read data, valid with memAck
memAck  in  1  memory completes the current request this cycle

Behaviour:
- Address fields:
  - word offset = address[2+log2(WORDS)-1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage per line: valid bit, tag, WORDS data words.
- States: IDLE, REFILL, WRITE, WDONE.
- Reset values (asynchronous):
  - state = IDLE; all valid bits = 0; refill counter = 0.
  - All outputs 0 while reset is high.
  - Reset during REFILL or WRITE aborts immediately: memReq drops combinationally, and the partially refilled line stays invalid.
- IDLE, MemRead only, line valid and tag matches:
  - hit=1, readData = stored word, stall=0 in the same cycle (zero extra latency).
- IDLE, MemRead only, miss:
  - hit=0, stall=1; latch the line base address; counter=0; go to REFILL.
- IDLE, MemWrite (MemWrite wins when MemRead is also high):
  - stall=1; latch address and writeData; go to WRITE.
  - If the line hits, update the cached word at this clock edge (write-update). Tag and valid are unchanged.
- REFILL:
  - memReq=1, memWe=0, memAddr = {latched tag, index, counter, 2'b00}; stall=1, hit=0.
  - On memAck: store memReadData into word[counter] and increment counter.
  - On memAck with counter=WORDS-1: set valid, write the tag, go to IDLE. The still-pending MemRead then hits in IDLE.
  - A new valid/tag is never visible before the final word is written.
- WRITE:
  - memReq=1, memWe=1, memAddr and memWriteData come from the latched values; stall=1.
  - On memAck go to WDONE.
- WDONE:
  - One cycle with stall=0, hit=1, readData=0; the pending store is consumed; go to IDLE.
- Handshake rules:
  - memAddr, memWe and memWriteData stay stable while memReq=1.
  - memAck is ignored when memReq=0.
  - memAck can arrive in the same cycle memReq rises; this completes the word.
- Boundaries:
  - A refill always fetches words 0..WORDS-1 in order; the counter wraps to 0 on exit.
  - A write miss never allocates a line.
  - When MemRead and MemWrite are both 0 in IDLE: stall=0, hit=0.
- Latencies: read hit 0 cycles; read miss WORDS acks + 1 cycle; write = ack + 1 cycle (WDONE).

Decomposition:
- Shared package holds:
  - the state encoding (2 bits)
  - field-width constants derived from LINES and WORDS (OFFSET_W, INDEX_W, TAG_W)
  - the word width of 32
- One sub-module, cache_line_array: valid/tag/data storage with a combinational read port and a synchronous word-write port. Its valid bits clear on the asynchronous reset. The FSM stays in data_cache_ctrl.

Test Plan:
1. Reset, then MemRead 0x40; memory model returns data = address and acks after 1 wait cycle. Required: stall=1; memAddr sequence 0x40, 0x44, 0x48, 0x4C; after the 4th ack, hit=1 and readData=0x40 in the next cycle.
2. Following test 1, MemRead 0x44. Required: hit=1, readData=0x44, stall=0 in the same cycle, memReq stays 0.
3. MemWrite 0x48 with 0xDEADBEEF. Required: memReq=1, memWe=1, memWriteData=0xDEADBEEF until ack, then one WDONE cycle with stall=0. A subsequent MemRead 0x48 hits with 0xDEADBEEF.
4. MemRead 0x440 (same index, different tag, LINES=16). Required: full refill that evicts the line; then MemRead 0x40 misses and refills again.
5. MemWrite 0x200 to an invalid line. Required: write-through only; a following MemRead 0x200 misses (no allocate).
6. Assert reset after 2 refill acks for 0x80. Required: memReq=0 immediately; after reset, MemRead 0x80 performs a full 4-word refill starting at 0x80.

Source files
------------

// File: rtl/data_cache_ctrl_pkg.sv
// Shared definitions for the MEM-stage data cache: FSM state encoding,
// word width, default geometry and field-width helpers.
// Pure declarations; no logic, no latency, no flow control.
package data_cache_ctrl_pkg;

    localparam int WORD_W    = 32;
    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;

    // Address split: {tag, index, offset, 2'b00}
    function automatic int offsetWidth(input int words);
        return $clog2(words);
    endfunction

    function automatic int indexWidth(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tagWidth(input int lines, input int words);
        return WORD_W - 2 - $clog2(words) - $clog2(lines);
    endfunction

    localparam int OFFSET_W = offsetWidth(DEF_WORDS);
    localparam int INDEX_W  = indexWidth(DEF_LINES);
    localparam int TAG_W    = tagWidth(DEF_LINES, DEF_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        WDONE  = 2'd3
    } cacheState_t;

endpackage

// File: rtl/data_cache_ctrl_line_array.sv
// Valid/tag/data storage for the direct-mapped cache lines.
// Latency: combinational read port, single-word write lands on the next CLK edge.
// Backpressure: none; writes are accepted every cycle wrEn is high.
// Ports: rd* select and return one line's valid/tag and one word;
//        wr* write one word, setValid/clrValid update the line at wrIndex
//        (setValid also writes wrTag). Valid bits clear on async reset.
module cache_line_array
    import data_cache_ctrl_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic [indexWidth(LINES)-1:0]  rdIndex,
    input  logic [offsetWidth(WORDS)-1:0] rdOffset,
    output logic                          rdValid,
    output logic [tagWidth(LINES,WORDS)-1:0] rdTag,
    output logic [WORD_W-1:0]             rdWord,
    input  logic                          wrEn,
    input  logic [indexWidth(LINES)-1:0]  wrIndex,
    input  logic [offsetWidth(WORDS)-1:0] wrOffset,
    input  logic [WORD_W-1:0]             wrData,
    input  logic                          setValid,
    input  logic                          clrValid,
    input  logic [tagWidth(LINES,WORDS)-1:0] wrTag
);

    localparam int TagW = tagWidth(LINES, WORDS);

    logic [LINES-1:0]  validBits;
    logic [TagW-1:0]   tagMem  [LINES];
    logic [WORD_W-1:0] dataMem [LINES*WORDS];

    assign rdValid = validBits[rdIndex];
    assign rdTag   = tagMem[rdIndex];
    assign rdWord  = dataMem[{rdIndex, rdOffset}];

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            validBits <= '0;
        end else if (setValid) begin
            validBits[wrIndex] <= 1'b1;
        end else if (clrValid) begin
            validBits[wrIndex] <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (setValid) begin
            tagMem[wrIndex] <= wrTag;
        end
        if (wrEn) begin
            dataMem[{wrIndex, wrOffset}] <= wrData;
        end
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller (MEM stage).
// Latency: read hit 0 cycles; read miss WORDS memory acks + 1; write = 1 ack + 1 (WDONE).
// Backpressure: stall freezes the pipeline during refill/write-through; memory side
// holds memReq with stable address/data until memAck.
// Ports: CLK/reset; MemRead/MemWrite/address/writeData from the pipeline;
//        readData/hit/stall to the pipeline; mem* single-word req/ack to main memory.
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hit,
    output logic        stall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    input  logic        memAck
);

    localparam int OffW = offsetWidth(WORDS);
    localparam int IdxW = indexWidth(LINES);
    localparam int TagW = tagWidth(LINES, WORDS);

    cacheState_t       state, nextState;
    logic [OffW-1:0]   refillCnt;
    logic [29:0]       latWordAddr;   // word address; low OffW bits zero during refill
    logic [31:0]       latData;

    logic [IdxW-1:0]   curIndex, latIndex, arrWrIndex;
    logic [OffW-1:0]   curOffset, arrWrOffset;
    logic [TagW-1:0]   curTag, latTag, lineTag;
    logic [31:0]       lineWord, arrWrData;
    logic              lineValid, lineHit;
    logic              arrWrEn, arrSetValid, arrClrValid;
    logic              startWrite, startRefill, refillAck;
    logic              unusedAddrBits;

    assign unusedAddrBits = ^address[1:0];

    assign curOffset = address[2 +: OffW];
    assign curIndex  = address[2+OffW +: IdxW];
    assign curTag    = address[31 -: TagW];
    assign latIndex  = latWordAddr[OffW +: IdxW];
    assign latTag    = latWordAddr[29 -: TagW];
    assign lineHit   = lineValid && (lineTag == curTag);

    // Store write-update uses the live pipeline address; refill uses the latched line.
    assign arrWrIndex  = (state == IDLE) ? curIndex  : latIndex;
    assign arrWrOffset = (state == IDLE) ? curOffset : refillCnt;
    assign arrWrData   = (state == IDLE) ? writeData : memReadData;

    cache_line_array #(.LINES(LINES), .WORDS(WORDS)) u_lines (
        .CLK      (CLK),
        .reset    (reset),
        .rdIndex  (curIndex),
        .rdOffset (curOffset),
        .rdValid  (lineValid),
        .rdTag    (lineTag),
        .rdWord   (lineWord),
        .wrEn     (arrWrEn),
        .wrIndex  (arrWrIndex),
        .wrOffset (arrWrOffset),
        .wrData   (arrWrData),
        .setValid (arrSetValid),
        .clrValid (arrClrValid),
        .wrTag    (latTag)
    );

    always_comb begin
        nextState    = state;
        readData     = '0;
        hit          = 1'b0;
        stall        = 1'b0;
        memReq       = 1'b0;
        memWe        = 1'b0;
        memAddr      = '0;
        memWriteData = '0;
        arrWrEn      = 1'b0;
        arrSetValid  = 1'b0;
        arrClrValid  = 1'b0;
        startWrite   = 1'b0;
        startRefill  = 1'b0;
        refillAck    = 1'b0;
        // Gating on reset drops memReq combinationally and blocks array writes.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (MemWrite) begin
                        stall      = 1'b1;
                        startWrite = 1'b1;
                        arrWrEn    = lineHit;
                        nextState  = WRITE;
                    end else if (MemRead) begin
                        if (lineHit) begin
                            hit      = 1'b1;
                            readData = lineWord;
                        end else begin
                            stall       = 1'b1;
                            startRefill = 1'b1;
                            // Evicted line goes invalid so partial data is never visible.
                            arrClrValid = 1'b1;
                            nextState   = REFILL;
                        end
                    end
                end
                REFILL: begin
                    memReq  = 1'b1;
                    memAddr = {latWordAddr[29:OffW], refillCnt, 2'b00};
                    stall   = 1'b1;
                    if (memAck) begin
                        refillAck = 1'b1;
                        arrWrEn   = 1'b1;
                        if (refillCnt == OffW'(WORDS-1)) begin
                            arrSetValid = 1'b1;
                            nextState   = IDLE;
                        end
                    end
                end
                WRITE: begin
                    memReq       = 1'b1;
                    memWe        = 1'b1;
                    memAddr      = {latWordAddr, 2'b00};
                    memWriteData = latData;
                    stall        = 1'b1;
                    if (memAck) begin
                        nextState = WDONE;
                    end
                end
                WDONE: begin
                    hit       = 1'b1;
                    nextState = IDLE;
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            refillCnt   <= '0;
            latWordAddr <= '0;
            latData     <= '0;
        end else begin
            state <= nextState;
            if (startWrite) begin
                latWordAddr <= address[31:2];
                latData     <= writeData;
            end else if (startRefill) begin
                latWordAddr <= {address[31:2+OffW], {OffW{1'b0}}};
                refillCnt   <= '0;
            end
            if (refillAck) begin
                refillCnt <= refillCnt + 1'b1;   // wraps to 0 after the last word
            end
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
module tb_data_cache_ctrl;

    logic        CLK = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] address, writeData;
    logic [31:0] readData;
    logic        hit, stall;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWriteData;
    logic [31:0] memReadData;
    logic        memAck;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    data_cache_ctrl #(.LINES(16), .WORDS(4)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .address      (address),
        .writeData    (writeData),
        .readData     (readData),
        .hit          (hit),
        .stall        (stall),
        .memReq       (memReq),
        .memWe        (memWe),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memReadData  (memReadData),
        .memAck       (memAck)
    );

    // Main-memory model: unwritten words read back as their own address;
    // each request waits one cycle before a one-cycle ack.
    logic [31:0] memModel [logic [31:0]];
    logic [31:0] ackAddrQ [$];
    logic        ackWeQ   [$];
    logic [31:0] ackWdQ   [$];

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return a;
    endfunction

    initial begin
        int          waitCnt;
        logic [31:0] pendAddr, pendWd;
        logic        pendWe;
        waitCnt     = 0;
        memAck      = 1'b0;
        memReadData = '0;
        pendAddr    = '0;
        pendWd      = '0;
        pendWe      = 1'b0;
        forever begin
            @(negedge CLK);
            if (memAck) begin
                memAck = 1'b0;
                ackAddrQ.push_back(pendAddr);
                ackWeQ.push_back(pendWe);
                ackWdQ.push_back(pendWd);
                waitCnt = 0;
            end else if (memReq) begin
                if (waitCnt < 1) begin
                    waitCnt++;
                end else begin
                    pendAddr    = memAddr;
                    pendWe      = memWe;
                    pendWd      = memWriteData;
                    memReadData = memRead(memAddr);
                    if (memWe) memModel[memAddr] = memWriteData;
                    memAck = 1'b1;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic doAccess(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, output int cyc,
                            output logic h, output logic [31:0] d);
        MemRead   = rd;
        MemWrite  = wr;
        address   = a;
        writeData = wd;
        #1;
        cyc = 0;
        while (stall && cyc < 200) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        chk("access_timeout", {31'b0, stall}, 32'd0);
        h        = hit;
        d        = readData;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expHit;
        logic [31:0] expData;
        int          expCycles;
        int          expAcks;
        logic [31:0] expFirst;
        logic        expWe;
    } vec_t;

    vec_t vecs [13];

    task automatic runVec(input int idx);
        int          base, cyc, n;
        logic        h;
        logic [31:0] d;
        string       tag;
        vec_t        v;
        v    = vecs[idx];
        base = ackAddrQ.size();
        doAccess(v.rd, v.wr, v.addr, v.wdata, cyc, h, d);
        n = ackAddrQ.size() - base;
        $sformat(tag, "v%0d@%08h", idx, v.addr);
        chk({tag, " hit"}, {31'b0, h}, {31'b0, v.expHit});
        chk({tag, " readData"}, d, v.expData);
        chk({tag, " cycles"}, cyc, v.expCycles);
        chk({tag, " memAcks"}, n, v.expAcks);
        for (int i = 0; i < n && i < v.expAcks; i++) begin
            chk({tag, " memAddr"}, ackAddrQ[base+i], v.expFirst + 32'(4*i));
            chk({tag, " memWe"}, {31'b0, ackWeQ[base+i]}, {31'b0, v.expWe});
            if (v.expWe) chk({tag, " memWriteData"}, ackWdQ[base+i], v.wdata);
        end
    endtask

    initial begin
        int base, guard;
        //           rd    wr    addr          wdata         hit   data          cyc ack first         we
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1'b1, 32'h0000_0040, 12, 4, 32'h0000_0040, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        1'b1, 32'h0000_0044, 0,  0, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0048, 32'hDEADBEEF, 1'b1, 32'h0,         3,  1, 32'h0000_0048, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,        1'b1, 32'hDEADBEEF,  0,  0, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0440, 32'h0,        1'b1, 32'h0000_0440, 12, 4, 32'h0000_0440, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1'b1, 32'h0000_0040, 12, 4, 32'h0000_0040, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,        1'b1, 32'hDEADBEEF,  0,  0, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h12345678, 1'b1, 32'h0,         3,  1, 32'h0000_0200, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,        1'b1, 32'h12345678,  12, 4, 32'h0000_0200, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_004C, 32'hCAFEF00D, 1'b1, 32'h0,         3,  1, 32'h0000_004C, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_004C, 32'h0,        1'b1, 32'hCAFEF00D,  0,  0, 32'h0,         1'b0};
        // After the mid-refill reset: every line is invalid again.
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        1'b1, 32'h0000_0080, 12, 4, 32'h0000_0080, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        1'b1, 32'h0000_0044, 12, 4, 32'h0000_0040, 1'b0};

        // Reset with a pending load: every output must stay 0.
        reset     = 1'b1;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        address   = 32'h40;
        writeData = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset hit", {31'b0, hit}, 32'd0);
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset memReq", {31'b0, memReq}, 32'd0);
        chk("reset readData", readData, 32'd0);
        chk("reset memAddr", memAddr, 32'd0);
        MemRead = 1'b0;
        reset   = 1'b0;
        @(posedge CLK);
        #1;
        chk("idle stall", {31'b0, stall}, 32'd0);
        chk("idle hit", {31'b0, hit}, 32'd0);
        chk("idle memReq", {31'b0, memReq}, 32'd0);

        for (int i = 0; i <= 10; i++) runVec(i);

        // Reset after two refill acks for 0x80 aborts the refill at once.
        base      = ackAddrQ.size();
        MemRead   = 1'b1;
        address   = 32'h80;
        guard     = 0;
        while (ackAddrQ.size() - base < 2 && guard < 100) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        chk("abort two acks seen", ackAddrQ.size() - base, 32'd2);
        chk("abort before reset memReq", {31'b0, memReq}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort memReq", {31'b0, memReq}, 32'd0);
        chk("abort stall", {31'b0, stall}, 32'd0);
        chk("abort hit", {31'b0, hit}, 32'd0);
        @(posedge CLK);
        #1;
        MemRead = 1'b0;
        reset   = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 11; i <= 12; i++) runVec(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
